// File: rtl/hc40103.sv
`default_nettype none
// ============================================================================
// Module  : hc40103
// Brief   : 74HC40103 8-bit presettable down-counter with active-low terminal count.
// Revision: 1.0
// ============================================================================
module hc40103 (
   input  logic p1,    // CP
   input  logic p2,    // /MR
   input  logic p3,    // /TE
   input  logic p4,    // P0
   input  logic p5,    // P1
   input  logic p6,    // P2
   input  logic p7,    // P3
   input  logic p9,    // /PL
   input  logic p10,   // P4
   input  logic p11,   // P5
   input  logic p12,   // P6
   input  logic p13,   // P7
   input  logic p15,   // /PE
   output logic p14    // /TC
);

   logic [7:0] preset;
   logic [7:0] cnt;
   logic [7:0] cnt_d;

   assign preset = {p13, p12, p11, p10, p7, p6, p5, p4};

   always_comb begin
      cnt_d = cnt;
      if (!p15) begin
         cnt_d = preset;
      end else if (!p3) begin
         cnt_d = cnt - 8'd1;
      end
   end

   // Each bit has its own async set/clear so /PL can follow the preset word
   // combinationally and still leave the loaded value behind on release.
   generate
      for (genvar i = 0; i < 8; i++) begin : g_bit
         logic bit_q;
         logic load_set;
         logic load_clr;

         assign load_set = ~p9 & preset[i];
         assign load_clr = p2 & ~p9 & ~preset[i];

         always_ff @(posedge p1 or negedge p2 or posedge load_set or posedge load_clr) begin
            if (!p2) begin
               bit_q <= 1'b1;
            end else if (!p9) begin
               bit_q <= preset[i];
            end else begin
               bit_q <= cnt_d[i];
            end
         end

         assign cnt[i] = bit_q;
      end
   endgenerate

   assign p14 = ~((cnt == 8'h00) & ~p3);

endmodule
`default_nettype wire

// File: tb/tb_hc40103.sv
`default_nettype none
// ============================================================================
// Module  : tb_hc40103
// Brief   : Self-checking bench for hc40103 against a count-level model.
// Revision: 1.0
// ============================================================================
module tb_hc40103;

   logic       clk = 1'b0;
   logic       r_p2 = 1'b1;
   logic       r_p9 = 1'b1;
   logic       r_p3 = 1'b1;
   logic       r_pe = 1'b1;
   logic       tie = 1'b0;
   logic [7:0] pw = 8'h00;
   logic       p14;
   logic       p15;

   int  m_cnt = 255;
   int  n_cmp = 0;
   int  n_bad = 0;
   bit  chk_en = 1'b0;

   // In divide mode /TC is strapped back onto /PE.
   assign p15 = tie ? p14 : r_pe;

   hc40103 dut (
      .p1 (clk),
      .p2 (r_p2),
      .p3 (r_p3),
      .p4 (pw[0]),
      .p5 (pw[1]),
      .p6 (pw[2]),
      .p7 (pw[3]),
      .p9 (r_p9),
      .p10(pw[4]),
      .p11(pw[5]),
      .p12(pw[6]),
      .p13(pw[7]),
      .p15(p15),
      .p14(p14)
   );

   initial forever #5 clk = ~clk;

   function automatic logic model_tc();
      return (m_cnt == 0 && r_p3 == 1'b0) ? 1'b0 : 1'b1;
   endfunction

   task automatic edge_model();
      logic pe_eff;
      if (r_p2 && r_p9) begin
         pe_eff = tie ? model_tc() : r_pe;
         if (!pe_eff)      m_cnt = int'(pw);
         else if (!r_p3)   m_cnt = (m_cnt + 255) % 256;
      end
   endtask

   task automatic async_model();
      if (!r_p2)       m_cnt = 255;
      else if (!r_p9)  m_cnt = int'(pw);
   endtask

   // One clock: model the edge, then change inputs 2 units later (mid-cycle).
   task automatic cyc(input logic mr, input logic pl, input logic te,
                      input logic pe, input logic tj, input logic [7:0] p);
      @(posedge clk);
      edge_model();
      #2;
      r_p2 = mr; r_p9 = pl; r_p3 = te; r_pe = pe; tie = tj; pw = p;
      async_model();
      #1;
   endtask

   task automatic hold();
      cyc(r_p2, r_p9, r_p3, r_pe, tie, pw);
   endtask

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic lit(input string nm, input logic [7:0] c, input logic t);
      logic [7:0] mc;
      mc = m_cnt[7:0];
      check({nm, " cnt"}, dut.cnt, c);
      check({nm, " tc"}, {7'd0, p14}, {7'd0, t});
      check({nm, " model"}, mc, c);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("cycle cnt", dut.cnt, m_cnt[7:0]);
         check("cycle tc", {7'd0, p14}, {7'd0, model_tc()});
      end
   end

   initial begin
      int lows;
      #1;
      r_p2 = 1'b0; r_p3 = 1'b0;
      async_model();
      chk_en = 1'b1;

      cyc(0, 1, 0, 1, 0, 8'h00);
      cyc(0, 1, 0, 1, 0, 8'h00);
      lit("reset", 8'hFF, 1'b1);
      cyc(1, 1, 0, 1, 0, 8'h00);
      lit("release", 8'hFF, 1'b1);
      hold(); lit("dec1", 8'hFE, 1'b1);
      hold(); lit("dec2", 8'hFD, 1'b1);
      hold(); lit("dec3", 8'hFC, 1'b1);

      cyc(1, 1, 0, 0, 0, 8'h03);
      cyc(1, 1, 0, 1, 0, 8'h03); lit("sload", 8'h03, 1'b1);
      hold(); lit("load-1", 8'h02, 1'b1);
      hold(); lit("load-2", 8'h01, 1'b1);
      hold(); lit("zero", 8'h00, 1'b0);
      hold(); lit("wrap", 8'hFF, 1'b1);

      cyc(1, 0, 0, 1, 0, 8'h04); lit("aload4", 8'h04, 1'b1);
      cyc(1, 1, 0, 1, 1, 8'h04);
      lows = 0;
      repeat (20) begin
         hold();
         if (p14 == 1'b0) lows++;
      end
      check("div5 lows", lows[7:0], 8'd4);

      cyc(1, 0, 0, 1, 0, 8'h00); lit("aload0", 8'h00, 1'b0);
      cyc(1, 1, 0, 1, 1, 8'h00);
      lows = 0;
      repeat (10) begin
         hold();
         if (p14 == 1'b0) lows++;
      end
      check("div1 lows", lows[7:0], 8'd10);

      cyc(1, 1, 1, 1, 0, 8'h00); lit("te high", 8'h00, 1'b1);
      repeat (4) hold();
      lit("te hold", 8'h00, 1'b1);
      cyc(1, 1, 0, 1, 0, 8'h00); lit("te low", 8'h00, 1'b0);

      hold(); lit("wrap2", 8'hFF, 1'b1);
      hold();
      cyc(1, 0, 0, 1, 0, 8'h5A); lit("pl 5A", 8'h5A, 1'b1);
      cyc(1, 0, 0, 1, 0, 8'h21); lit("pl track", 8'h21, 1'b1);
      cyc(1, 1, 0, 1, 0, 8'h21); lit("pl release", 8'h21, 1'b1);
      hold(); lit("pl count", 8'h20, 1'b1);

      cyc(1, 0, 0, 1, 0, 8'h03);
      cyc(1, 1, 0, 1, 0, 8'h03);
      hold(); lit("at2", 8'h02, 1'b1);
      cyc(0, 1, 0, 0, 0, 8'h77); lit("mr mid", 8'hFF, 1'b1);
      repeat (3) hold();
      lit("mr held", 8'hFF, 1'b1);
      cyc(1, 1, 0, 1, 0, 8'h77); lit("mr release", 8'hFF, 1'b1);
      hold(); lit("mr count", 8'hFE, 1'b1);

      for (int i = 0; i < 600; i++) begin
         logic tj;
         tj = (i / 40) % 2 == 1 ? ($urandom_range(0, 1) == 1) : 1'b0;
         if (i % 40 != 0) tj = tie;
         cyc(($urandom_range(0, 99) < 4)  ? 1'b0 : 1'b1,
             ($urandom_range(0, 99) < 6)  ? 1'b0 : 1'b1,
             ($urandom_range(0, 99) < 70) ? 1'b0 : 1'b1,
             ($urandom_range(0, 99) < 10) ? 1'b0 : 1'b1,
             tj, 8'($urandom_range(0, 255)));
      end

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
